// File: rtl/switch_ctrl_pkg.sv
// switch_ctrl_pkg
//   Shared definitions for the DIP-switch bank controller:
//   - register word addresses on the peripheral bus (ADR_I)
//   - debounce FSM state encoding
package switch_ctrl_pkg;

  localparam logic [1:0] ADR_VALUE = 2'd0;  // debounced switch word, read-only
  localparam logic [1:0] ADR_CHG   = 2'd1;  // per-bit change flags, write-1-to-clear
  localparam logic [1:0] ADR_MASK  = 2'd2;  // per-bit interrupt enable
  localparam logic [1:0] ADR_RAW   = 2'd3;  // second synchroniser stage, read-only

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/switch_debounce.sv
// switch_debounce
//   Two-flop synchroniser plus whole-vector debouncer for the 32-bit switch
//   word. A single counter is shared by all bits: any change in the
//   synchronised word restarts the settle count.
// Ports
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_sw       raw switch word, asynchronous to i_clk
//   o_value    debounced switch word
//   o_sync2    second synchroniser stage
//   o_upd_vec  old^new vector, nonzero only in the cycle value is loaded
module switch_debounce
  import switch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_sw,
  output logic [31:0] o_value,
  output logic [31:0] o_sync2,
  output logic [31:0] o_upd_vec
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [31:0]      r_sync1;
  logic [31:0]      r_sync2;
  logic [31:0]      r_cand;
  logic [31:0]      r_value;
  logic [CNT_W-1:0] r_cnt;
  deb_state_t       r_state;
  logic             w_done;

  // The update is exposed combinationally so the change flags in the parent
  // load on the same edge as r_value.
  assign w_done = (r_state == SETTLING) && (r_sync2 == r_cand) && (r_cnt == CNT_LAST);

  assign o_value   = r_value;
  assign o_sync2   = r_sync2;
  assign o_upd_vec = w_done ? (r_value ^ r_cand) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_value <= '0;
      r_cnt   <= '0;
      r_state <= STABLE;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      case (r_state)
        STABLE: begin
          if (r_sync2 != r_cand) begin
            r_cand  <= r_sync2;
            r_cnt   <= '0;
            r_state <= SETTLING;
          end
        end
        SETTLING: begin
          if (r_sync2 != r_cand) begin
            // bounce: restart the full settle window from this edge
            r_cand <= r_sync2;
            r_cnt  <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_value <= r_cand;
            r_state <= STABLE;
          end else begin
            // cannot wrap: it stops at CNT_LAST
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= STABLE;
      endcase
    end
  end

endmodule

// File: rtl/switch_ctrl.sv
// switch_ctrl
//   Bus-slave controller for the 32-bit DIP-switch bank. Debounces the switch
//   word, keeps per-bit change flags and raises a maskable level interrupt.
// Ports
//   CLK_I   system clock, rising edge
//   RST_I   asynchronous active-high reset
//   SW_I    raw switch word (bit i = DIPSW i)
//   CYC_I   bus cycle valid
//   STB_I   strobe / slave select
//   WE_I    1 = write, 0 = read
//   ADR_I   word address: 0 VALUE, 1 CHG, 2 MASK, 3 RAW
//   DAT_I   write data
//   DAT_O   read data, zero whenever ACK_O is low
//   ACK_O   single-cycle transfer acknowledge
//   IRQ_O   |(CHG & MASK)
module switch_ctrl
  import switch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] SW_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [1:0]  ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        IRQ_O
);

  logic [31:0] w_value;
  logic [31:0] w_sync2;
  logic [31:0] w_upd_vec;
  logic [31:0] w_rd_data;
  logic [31:0] w_chg_clr;
  logic        w_acc;
  logic        w_wr;

  logic [31:0] r_chg;
  logic [31:0] r_mask;
  logic [31:0] r_dat;
  logic        r_ack;

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk    (CLK_I),
    .i_rst    (RST_I),
    .i_sw     (SW_I),
    .o_value  (w_value),
    .o_sync2  (w_sync2),
    .o_upd_vec(w_upd_vec)
  );

  // Masking with ~r_ack makes a held strobe acknowledge every second cycle.
  assign w_acc     = CYC_I & STB_I & ~r_ack;
  assign w_wr      = w_acc & WE_I;
  assign w_chg_clr = (w_wr && (ADR_I == ADR_CHG)) ? DAT_I : '0;

  always_comb begin
    w_rd_data = '0;
    case (ADR_I)
      ADR_VALUE: w_rd_data = w_value;
      ADR_CHG:   w_rd_data = r_chg;
      ADR_MASK:  w_rd_data = r_mask;
      default:   w_rd_data = w_sync2;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_chg  <= '0;
      r_mask <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !WE_I) ? w_rd_data : '0;
      // set is OR-ed after the clear so a simultaneous update wins
      r_chg <= (r_chg & ~w_chg_clr) | w_upd_vec;
      if (w_wr && (ADR_I == ADR_MASK)) begin
        r_mask <= DAT_I;
      end
    end
  end

  assign ACK_O = r_ack;
  assign DAT_O = r_dat;
  assign IRQ_O = |(r_chg & r_mask);

endmodule
